wf_retire_ctrl: RTL and testbench
=================================

// Module: wf_retire_ctrl
// PURPOSE
// Consumer end of the finished-wavefront interface (fetchwave_wf_done_en/_wf_id).
// Records done events per slot, arbitrates them round-robin, and reports each one
// to the dispatcher over a valid/ack handshake using the tag captured at dispatch.
// Frees the wavefront slot on ack. Sits between issue/fetch and the CU dispatch
// interface.
// PARAMETERS
// WF_ID_LENGTH  6   width of a wavefront slot id
// WF_PER_CU     40  number of wavefront slots; legal ids 0..WF_PER_CU-1
// TAG_WIDTH     15  width of the dispatcher wavefront tag
// PORTS
// clk                       in   1             clock; all state on rising edge
// rst                       in   1             synchronous reset, active-high
// dispatch2cu_wf_dispatch   in   1             dispatcher writes a new wf this cycle
// dispatch2cu_wf_id         in   WF_ID_LENGTH  slot receiving the dispatched wf
// dispatch2cu_wf_tag        in   TAG_WIDTH     tag of the dispatched wf
// fetchwave_wf_done_en      in   1             finished-wf pulse from issue
// fetchwave_wf_done_wf_id   in   WF_ID_LENGTH  slot that finished
// dispatch2cu_wf_done_ack   in   1             dispatcher accepts the current done report
// cu2dispatch_wf_done       out  1             done report valid (registered)
// cu2dispatch_wf_done_wfid  out  WF_ID_LENGTH  slot being reported (registered)
// cu2dispatch_wf_tag_done   out  TAG_WIDTH     tag of reported slot (registered)
// wf_busy_array             out  WF_PER_CU     1 = slot holds a live or unreported wf
// wf_done_pending_array     out  WF_PER_CU     1 = done received, not yet acked
// protocol_err              out  1             sticky error flag
// BEHAVIOUR
// - Reset: all outputs 0; busy, pending and tag tables 0; FSM IDLE; rr_ptr 0.
// - Dispatch: if the slot is not busy, set busy[id] and tag[id] next edge.
//   Dispatch to a busy slot or an id >= WF_PER_CU: ignored, protocol_err <= 1.
// - Done: if busy[id] and !pending[id], set pending[id] next edge.
//   Done on a non-busy slot or an out-of-range id: ignored, protocol_err <= 1.
//   Done on an already-pending slot: ignored, no error.
// - FSM IDLE: if any pending bit is set, select the first set bit searching from
//   rr_ptr upward with wrap (WF_PER_CU-1 -> 0). Register done=1, wfid and
//   tag[wfid]; go to REQ.
// - FSM REQ: hold done, wfid and tag stable until ack. On ack, at that edge:
//   clear busy[wfid], pending[wfid] and tag[wfid]; drop done; rr_ptr <= wfid+1
//   (wrap to 0); go to IDLE.
// - ack while done=0: ignored, protocol_err <= 1.
// - Latency: done_en in cycle N -> pending visible N+1 -> done report N+2
//   (FSM idle). After ack in cycle M, the next report is asserted no earlier
//   than M+2.
// - Simultaneous events in one cycle: dispatch and done to different slots both
//   take effect. A dispatch to the slot being acked sees it busy, so it is
//   ignored with an error. A done arriving in the same cycle the FSM selects is
//   recorded and served in a later round.
// - Fully occupied: all 40 slots may be pending at once; the bitmap cannot
//   overflow.
// - Reset mid-handshake: done drops next cycle; all slots are freed; no ack is
//   expected.
// - protocol_err clears only on rst.
// TESTING
// 1 Reset: outputs 0 and busy=0 after rst; rst during REQ -> done=0 next cycle.
// 2 Dispatch id5 tag 0x1A3; done_en id5 cycle N -> done=1,wfid=5,tag=0x1A3 at N+2;
//   ack -> busy[5]=0 next cycle.
// 3 Dispatch ids 3,7,39 then done all three in one window -> order 3,7,39; then
//   done id 3 again -> served after 39 (rr wrap).
// 4 Hold ack low 20 cycles -> done/wfid/tag stable throughout; second done on
//   the same slot -> no change, no error.
// 5 done_en id 10 with slot 10 idle -> pending unchanged, protocol_err=1;
//   ack while done=0 -> err stays 1.
// 6 Ack id 4 while dispatching id 4 same cycle -> id 4 freed, not re-busied,
//   protocol_err=1.

Source files
------------

// File: rtl/wf_retire_if.sv
// Handshake bundle between the dispatcher/issue side and the wavefront retire controller.
// The master drives dispatch, done and ack inputs; the slave returns the done report.
interface wf_retire_if #(
    parameter int WF_ID_LENGTH = 6,
    parameter int TAG_WIDTH    = 15
);
    logic                    dispatch2cu_wf_dispatch;
    logic [WF_ID_LENGTH-1:0] dispatch2cu_wf_id;
    logic [TAG_WIDTH-1:0]    dispatch2cu_wf_tag;
    logic                    fetchwave_wf_done_en;
    logic [WF_ID_LENGTH-1:0] fetchwave_wf_done_wf_id;
    logic                    dispatch2cu_wf_done_ack;
    logic                    cu2dispatch_wf_done;
    logic [WF_ID_LENGTH-1:0] cu2dispatch_wf_done_wfid;
    logic [TAG_WIDTH-1:0]    cu2dispatch_wf_tag_done;

    modport master (
        output dispatch2cu_wf_dispatch, dispatch2cu_wf_id, dispatch2cu_wf_tag,
        output fetchwave_wf_done_en, fetchwave_wf_done_wf_id, dispatch2cu_wf_done_ack,
        input  cu2dispatch_wf_done, cu2dispatch_wf_done_wfid, cu2dispatch_wf_tag_done
    );

    modport slave (
        input  dispatch2cu_wf_dispatch, dispatch2cu_wf_id, dispatch2cu_wf_tag,
        input  fetchwave_wf_done_en, fetchwave_wf_done_wf_id, dispatch2cu_wf_done_ack,
        output cu2dispatch_wf_done, cu2dispatch_wf_done_wfid, cu2dispatch_wf_tag_done
    );
endinterface

// File: rtl/wf_retire_ctrl.sv
// Wavefront retire controller: tracks busy/pending slots, picks finished slots
// round-robin and reports each to the dispatcher over a valid/ack handshake.
module wf_retire_ctrl #(
    parameter int WF_ID_LENGTH = 6,
    parameter int WF_PER_CU    = 40,
    parameter int TAG_WIDTH    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    wf_retire_if.slave           bus,
    output logic [WF_PER_CU-1:0] wf_busy_array,
    output logic [WF_PER_CU-1:0] wf_done_pending_array,
    output logic                 protocol_err
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    localparam logic [WF_ID_LENGTH:0]   NUM_SLOTS = (WF_ID_LENGTH + 1)'(WF_PER_CU);
    localparam logic [WF_ID_LENGTH-1:0] LAST_ID   = WF_ID_LENGTH'(WF_PER_CU - 1);

    state_t                  state_r, state_n;
    logic [WF_PER_CU-1:0]    busy_r, busy_n, pending_r, pending_n;
    logic [TAG_WIDTH-1:0]    tag_r [WF_PER_CU];
    logic                    done_r, done_n;
    logic [WF_ID_LENGTH-1:0] wfid_r, wfid_n, rr_ptr_r, rr_ptr_n;
    logic [TAG_WIDTH-1:0]    tag_done_r, tag_done_n;
    logic                    err_r, err_n;
    logic                    disp_ok_s, done_ok_s, ack_fire_s, sel_found_s;
    logic [WF_ID_LENGTH-1:0] sel_idx_s;
    logic [WF_ID_LENGTH:0]   scan_s;

    // Qualify incoming dispatch/done/ack events against the current slot state.
    always_comb begin
        disp_ok_s  = 1'b0;
        done_ok_s  = 1'b0;
        err_n      = err_r;
        ack_fire_s = (state_r == ST_REQ) && bus.dispatch2cu_wf_done_ack;
        if (bus.dispatch2cu_wf_dispatch) begin
            if (({1'b0, bus.dispatch2cu_wf_id} < NUM_SLOTS) && !busy_r[bus.dispatch2cu_wf_id]) begin
                disp_ok_s = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else begin
            disp_ok_s = 1'b0;
        end
        // A repeated done on an already-pending slot is silently dropped.
        if (bus.fetchwave_wf_done_en) begin
            if (({1'b0, bus.fetchwave_wf_done_wf_id} < NUM_SLOTS) && busy_r[bus.fetchwave_wf_done_wf_id]) begin
                done_ok_s = !pending_r[bus.fetchwave_wf_done_wf_id];
            end else begin
                err_n = 1'b1;
            end
        end else begin
            done_ok_s = 1'b0;
        end
        if (bus.dispatch2cu_wf_done_ack && (state_r != ST_REQ)) begin
            err_n = 1'b1;
        end else begin
            err_n = err_n;
        end
    end

    // Next busy/pending bitmaps; an acked slot is never re-busied in the same cycle.
    always_comb begin
        busy_n    = busy_r;
        pending_n = pending_r;
        if (disp_ok_s) begin
            busy_n[bus.dispatch2cu_wf_id] = 1'b1;
        end else begin
            busy_n = busy_n;
        end
        if (done_ok_s) begin
            pending_n[bus.fetchwave_wf_done_wf_id] = 1'b1;
        end else begin
            pending_n = pending_n;
        end
        if (ack_fire_s) begin
            busy_n[wfid_r]    = 1'b0;
            pending_n[wfid_r] = 1'b0;
        end else begin
            busy_n = busy_n;
        end
    end

    // Round-robin search: first pending slot at or above rr_ptr, wrapping at the last slot.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        scan_s      = '0;
        for (int i = 0; i < WF_PER_CU; i++) begin
            scan_s = {1'b0, rr_ptr_r} + (WF_ID_LENGTH + 1)'(i);
            if (scan_s >= NUM_SLOTS) begin
                scan_s = scan_s - NUM_SLOTS;
            end else begin
                scan_s = scan_s;
            end
            if (!sel_found_s && pending_r[scan_s[WF_ID_LENGTH-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = scan_s[WF_ID_LENGTH-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Report FSM next state and registered report fields.
    always_comb begin
        state_n    = state_r;
        done_n     = done_r;
        wfid_n     = wfid_r;
        tag_done_n = tag_done_r;
        rr_ptr_n   = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_n    = ST_REQ;
                    done_n     = 1'b1;
                    wfid_n     = sel_idx_s;
                    tag_done_n = tag_r[sel_idx_s];
                end else begin
                    done_n = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.dispatch2cu_wf_done_ack) begin
                    state_n  = ST_IDLE;
                    done_n   = 1'b0;
                    rr_ptr_n = (wfid_r == LAST_ID) ? '0 : wfid_r + WF_ID_LENGTH'(1);
                end else begin
                    done_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                done_n  = 1'b0;
            end
        endcase
    end

    // Control state, bitmaps and report registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= '0;
            pending_r  <= '0;
            done_r     <= 1'b0;
            wfid_r     <= '0;
            tag_done_r <= '0;
            rr_ptr_r   <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            busy_r     <= busy_n;
            pending_r  <= pending_n;
            done_r     <= done_n;
            wfid_r     <= wfid_n;
            tag_done_r <= tag_done_n;
            rr_ptr_r   <= rr_ptr_n;
            err_r      <= err_n;
        end
    end

    // Tag table: written on an accepted dispatch, cleared when the slot is acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WF_PER_CU; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (ack_fire_s) begin
                tag_r[wfid_r] <= '0;
            end
            if (disp_ok_s) begin
                tag_r[bus.dispatch2cu_wf_id] <= bus.dispatch2cu_wf_tag;
            end
        end
    end

    assign bus.cu2dispatch_wf_done      = done_r;
    assign bus.cu2dispatch_wf_done_wfid = wfid_r;
    assign bus.cu2dispatch_wf_tag_done  = tag_done_r;
    assign wf_busy_array                = busy_r;
    assign wf_done_pending_array        = pending_r;
    assign protocol_err                 = err_r;
endmodule

// File: tb/tb_wf_retire_ctrl.sv
// Bench for wf_retire_ctrl: directed scenarios plus random traffic, every cycle
// compared against a slot-table reference model.
module tb_wf_retire_ctrl;
    localparam int NW = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NW-1:0]   busy_arr, pend_arr;
    logic            perr;
    int              n_checks = 0;
    int              n_errors = 0;

    wf_retire_if #(.WF_ID_LENGTH(6), .TAG_WIDTH(15)) bus ();

    wf_retire_ctrl #(.WF_ID_LENGTH(6), .WF_PER_CU(NW), .TAG_WIDTH(15)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bus                   (bus),
        .wf_busy_array         (busy_arr),
        .wf_done_pending_array (pend_arr),
        .protocol_err          (perr)
    );

    always #5 clk = ~clk;

    // reference model: slot tables plus the report currently offered
    bit          m_busy [NW];
    bit          m_pend [NW];
    logic [14:0] m_tag  [NW];
    bit          m_done;
    int          m_wfid;
    logic [14:0] m_tagd;
    int          m_rr;
    bit          m_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] pack(input bit a [NW]);
        logic [NW-1:0] v;
        for (int i = 0; i < NW; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_step();
        bit          nb [NW];
        bit          np [NW];
        logic [14:0] nt [NW];
        int          did, wid;
        if (rst) begin
            for (int i = 0; i < NW; i++) begin
                m_busy[i] = 0; m_pend[i] = 0; m_tag[i] = '0;
            end
            m_done = 0; m_wfid = 0; m_tagd = '0; m_rr = 0; m_err = 0;
            return;
        end
        nb = m_busy; np = m_pend; nt = m_tag;
        did = int'(bus.dispatch2cu_wf_id);
        wid = int'(bus.fetchwave_wf_done_wf_id);
        if (bus.dispatch2cu_wf_done_ack && !m_done) m_err = 1;
        if (bus.dispatch2cu_wf_dispatch) begin
            if (did >= NW || m_busy[did]) m_err = 1;
            else begin nb[did] = 1; nt[did] = bus.dispatch2cu_wf_tag; end
        end
        if (bus.fetchwave_wf_done_en) begin
            if (wid >= NW || !m_busy[wid]) m_err = 1;
            else if (!m_pend[wid]) np[wid] = 1;
        end
        if (m_done) begin
            if (bus.dispatch2cu_wf_done_ack) begin
                nb[m_wfid] = 0; np[m_wfid] = 0; nt[m_wfid] = '0;
                m_done = 0;
                m_rr = (m_wfid + 1) % NW;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                int j = (m_rr + k) % NW;
                if (!m_done && m_pend[j]) begin
                    m_done = 1; m_wfid = j; m_tagd = m_tag[j];
                end
            end
        end
        m_busy = nb; m_pend = np; m_tag = nt;
    endtask

    task automatic clear_in();
        rst = 1'b0;
        bus.dispatch2cu_wf_dispatch = 1'b0;
        bus.dispatch2cu_wf_id       = '0;
        bus.dispatch2cu_wf_tag      = '0;
        bus.fetchwave_wf_done_en    = 1'b0;
        bus.fetchwave_wf_done_wf_id = '0;
        bus.dispatch2cu_wf_done_ack = 1'b0;
    endtask

    // one clock: model and DUT see the same inputs, then outputs are compared
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("done", bus.cu2dispatch_wf_done, m_done);
        check_val("busy", busy_arr, pack(m_busy));
        check_val("pending", pend_arr, pack(m_pend));
        check_val("err", perr, m_err);
        if (m_done) begin
            check_val("wfid", bus.cu2dispatch_wf_done_wfid, m_wfid);
            check_val("tag", bus.cu2dispatch_wf_tag_done, m_tagd);
        end
        clear_in();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    task automatic disp(input int id, input int tg);
        bus.dispatch2cu_wf_dispatch = 1'b1;
        bus.dispatch2cu_wf_id       = 6'(id);
        bus.dispatch2cu_wf_tag      = 15'(tg);
        tick();
    endtask

    task automatic wdone(input int id);
        bus.fetchwave_wf_done_en    = 1'b1;
        bus.fetchwave_wf_done_wf_id = 6'(id);
        tick();
    endtask

    task automatic serve(input int exp_id);
        int n = 0;
        while (!bus.cu2dispatch_wf_done && n < 50) begin
            tick();
            n++;
        end
        check_val("serve_valid", bus.cu2dispatch_wf_done, 1);
        check_val("serve_wfid", bus.cu2dispatch_wf_done_wfid, exp_id);
        bus.dispatch2cu_wf_done_ack = 1'b1;
        tick();
    endtask

    initial begin
        clear_in();
        // reset state
        do_reset();
        check_val("rst_done", bus.cu2dispatch_wf_done, 0);
        check_val("rst_busy", busy_arr, 0);
        check_val("rst_err", perr, 0);

        // single report with latency N+2
        disp(5, 'h1A3);
        wdone(5);
        check_val("lat_pend5", pend_arr[5], 1);
        check_val("lat_n1_done", bus.cu2dispatch_wf_done, 0);
        tick();
        check_val("lat_n2_done", bus.cu2dispatch_wf_done, 1);
        check_val("lat_wfid", bus.cu2dispatch_wf_done_wfid, 5);
        check_val("lat_tag", bus.cu2dispatch_wf_tag_done, 'h1A3);
        bus.dispatch2cu_wf_done_ack = 1'b1;
        tick();
        check_val("ack_busy5", busy_arr[5], 0);

        // round-robin order and wrap
        do_reset();
        disp(3, 'h003); disp(7, 'h007); disp(39, 'h027);
        wdone(3); wdone(7); wdone(39);
        serve(3);
        disp(3, 'h333);
        serve(7);
        wdone(3);
        serve(39);
        serve(3);

        // stall with ack low; repeated done is harmless
        do_reset();
        disp(12, 'h5A5);
        wdone(12);
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 8) begin
                bus.fetchwave_wf_done_en    = 1'b1;
                bus.fetchwave_wf_done_wf_id = 6'd12;
            end
            tick();
            check_val("hold_done", bus.cu2dispatch_wf_done, 1);
            check_val("hold_wfid", bus.cu2dispatch_wf_done_wfid, 12);
            check_val("hold_tag", bus.cu2dispatch_wf_tag_done, 'h5A5);
            check_val("hold_err", perr, 0);
        end
        bus.dispatch2cu_wf_done_ack = 1'b1;
        tick();
        check_val("hold_release", bus.cu2dispatch_wf_done, 0);

        // done on idle slot, then stray ack
        do_reset();
        wdone(10);
        check_val("idle_pend10", pend_arr[10], 0);
        check_val("idle_err", perr, 1);
        bus.dispatch2cu_wf_done_ack = 1'b1;
        tick();
        check_val("stray_ack_err", perr, 1);

        // ack and dispatch to the same slot in one cycle
        do_reset();
        disp(4, 'h044);
        wdone(4);
        tick();
        bus.dispatch2cu_wf_done_ack = 1'b1;
        bus.dispatch2cu_wf_dispatch = 1'b1;
        bus.dispatch2cu_wf_id       = 6'd4;
        bus.dispatch2cu_wf_tag      = 15'h099;
        tick();
        check_val("same_busy4", busy_arr[4], 0);
        check_val("same_err", perr, 1);

        // reset during a pending report
        do_reset();
        disp(1, 'h011);
        wdone(1);
        tick();
        check_val("mid_done_pre", bus.cu2dispatch_wf_done, 1);
        do_reset();
        check_val("mid_done", bus.cu2dispatch_wf_done, 0);
        check_val("mid_busy", busy_arr, 0);

        // every slot pending at once, served in slot order
        do_reset();
        for (int i = 0; i < NW; i++) disp(i, i + 'h100);
        for (int i = 0; i < NW; i++) wdone(i);
        tick();
        check_val("full_pend", pend_arr, {NW{1'b1}});
        for (int i = 0; i < NW; i++) serve(i);
        check_val("full_free", busy_arr, 0);

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int live [$];
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if ($urandom_range(0, 9) < 3) begin
                bus.dispatch2cu_wf_dispatch = 1'b1;
                bus.dispatch2cu_wf_id  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63))
                                                                       : 6'($urandom_range(0, 39));
                bus.dispatch2cu_wf_tag = 15'($urandom);
            end
            if ($urandom_range(0, 9) < 4) begin
                live.delete();
                for (int i = 0; i < NW; i++) if (m_busy[i]) live.push_back(i);
                bus.fetchwave_wf_done_en = 1'b1;
                if (live.size() > 0 && $urandom_range(0, 9) != 0)
                    bus.fetchwave_wf_done_wf_id = 6'(live[$urandom_range(0, live.size() - 1)]);
                else
                    bus.fetchwave_wf_done_wf_id = 6'($urandom_range(0, 63));
            end
            if (m_done) bus.dispatch2cu_wf_done_ack = ($urandom_range(0, 9) < 4);
            else        bus.dispatch2cu_wf_done_ack = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
